// File: rtl/pipe_mips_param.sv
// Five-stage in-order MIPS-style pipeline with full EX forwarding, load-use
// interlock, EX-resolved branches and a draining HLT that freezes the core.
module pipe_mips_param #(
  parameter int XLEN = 32,
  parameter int IAW  = 10,
  parameter int DAW  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [IAW-1:0]  imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [DAW-1:0]  dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            halted
);
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010,
                         OP_OR = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101,
                         OP_LW = 6'b001000, OP_SW = 6'b001001, OP_ADDI = 6'b001010,
                         OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
                         OP_BEQZ = 6'b001110, OP_HLT = 6'b111111;

  logic [IAW-1:0]  pc;
  logic [XLEN-1:0] regs [32];

  logic            ifid_valid;
  logic [31:0]     ifid_ir;
  logic [IAW-1:0]  ifid_pc;

  logic            idex_valid, idex_wr;
  logic [5:0]      idex_op;
  logic [4:0]      idex_rs, idex_rt, idex_dest;
  logic [XLEN-1:0] idex_a, idex_b, idex_imm;
  logic [IAW-1:0]  idex_pc;

  logic            exmem_valid, exmem_wr;
  logic [5:0]      exmem_op;
  logic [4:0]      exmem_dest;
  logic [XLEN-1:0] exmem_alu, exmem_b;

  logic            memwb_valid, memwb_wr, memwb_hlt;
  logic [4:0]      memwb_dest;
  logic [XLEN-1:0] memwb_res;

  logic [5:0]      id_op;
  logic [4:0]      id_rs, id_rt, id_dest;
  logic            id_wr;
  logic [XLEN-1:0] id_a, id_b, id_imm;
  logic            wb_we, exmem_fwd;
  logic [XLEN-1:0] exmem_val, fa, fb, alu;
  logic            br_taken, stall, hlt_freeze;
  logic [IAW-1:0]  br_target;

  assign id_rs     = ifid_ir[25:21];
  assign id_rt     = ifid_ir[20:16];
  assign id_imm    = {{(XLEN-16){ifid_ir[15]}}, ifid_ir[15:0]};
  assign wb_we     = memwb_valid && memwb_wr && (memwb_dest != 5'd0);
  assign exmem_fwd = exmem_valid && exmem_wr && (exmem_dest != 5'd0);
  assign exmem_val = (exmem_op == OP_LW) ? dmem_rdata : exmem_alu;
  assign br_target = idex_pc + IAW'(1) + idex_imm[IAW-1:0];

  assign imem_addr  = pc;
  assign dmem_addr  = exmem_alu[DAW-1:0];
  assign dmem_wdata = exmem_b;
  assign dmem_we    = exmem_valid && (exmem_op == OP_SW) && !halted;
  assign dbg_rdata  = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

  // Decode: unknown opcodes collapse to HLT; pick destination field.
  always_comb begin
    id_op   = OP_HLT;
    id_dest = 5'd0;
    id_wr   = 1'b0;
    case (ifid_ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_LW, OP_SW, OP_ADDI,
      OP_SUBI, OP_SLTI, OP_BNEQZ, OP_BEQZ: id_op = ifid_ir[31:26];
      default: id_op = OP_HLT;
    endcase
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        id_dest = ifid_ir[15:11];
        id_wr   = 1'b1;
      end
      OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: begin
        id_dest = id_rt;
        id_wr   = 1'b1;
      end
      default: begin
        id_dest = 5'd0;
        id_wr   = 1'b0;
      end
    endcase
  end

  // Write-first register read: the retiring WB value bypasses the array.
  always_comb begin
    if (id_rs == 5'd0) id_a = '0;
    else if (wb_we && memwb_dest == id_rs) id_a = memwb_res;
    else id_a = regs[id_rs];
    if (id_rt == 5'd0) id_b = '0;
    else if (wb_we && memwb_dest == id_rt) id_b = memwb_res;
    else id_b = regs[id_rt];
  end

  // Execute: forwarded operands, ALU and branch resolution.
  always_comb begin
    if (exmem_fwd && exmem_dest == idex_rs) fa = exmem_val;
    else if (wb_we && memwb_dest == idex_rs) fa = memwb_res;
    else fa = idex_a;
    if (exmem_fwd && exmem_dest == idex_rt) fb = exmem_val;
    else if (wb_we && memwb_dest == idex_rt) fb = memwb_res;
    else fb = idex_b;
    case (idex_op)
      OP_ADD:                alu = fa + fb;
      OP_SUB:                alu = fa - fb;
      OP_AND:                alu = fa & fb;
      OP_OR:                 alu = fa | fb;
      OP_SLT:                alu = {{(XLEN-1){1'b0}}, ($signed(fa) < $signed(fb))};
      OP_MUL:                alu = fa * fb;
      OP_LW, OP_SW, OP_ADDI: alu = fa + idex_imm;
      OP_SUBI:               alu = fa - idex_imm;
      OP_SLTI:               alu = {{(XLEN-1){1'b0}}, ($signed(fa) < $signed(idex_imm))};
      default:               alu = '0;
    endcase
    br_taken = idex_valid && (((idex_op == OP_BEQZ) && (fa == '0)) ||
                              ((idex_op == OP_BNEQZ) && (fa != '0)));
  end

  // Hazard control: flush beats load-use stall; any HLT in flight stops fetch.
  always_comb begin
    stall = !br_taken && idex_valid && (idex_op == OP_LW) && (idex_rt != 5'd0) &&
            ifid_valid && ((id_rs == idex_rt) || (id_rt == idex_rt));
    hlt_freeze = (ifid_valid && id_op == OP_HLT) || (idex_valid && idex_op == OP_HLT) ||
                 (exmem_valid && exmem_op == OP_HLT) || (memwb_valid && memwb_hlt);
  end

  // Pipeline registers, PC and halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;        halted <= 1'b0;
      ifid_valid <= 1'b0; ifid_ir <= 32'd0; ifid_pc <= '0;
      idex_valid <= 1'b0; idex_wr <= 1'b0; idex_op <= 6'd0; idex_rs <= 5'd0;
      idex_rt <= 5'd0; idex_dest <= 5'd0; idex_a <= '0; idex_b <= '0;
      idex_imm <= '0; idex_pc <= '0;
      exmem_valid <= 1'b0; exmem_wr <= 1'b0; exmem_op <= 6'd0; exmem_dest <= 5'd0;
      exmem_alu <= '0; exmem_b <= '0;
      memwb_valid <= 1'b0; memwb_wr <= 1'b0; memwb_hlt <= 1'b0;
      memwb_dest <= 5'd0; memwb_res <= '0;
    end else if (!halted) begin
      if (br_taken) pc <= br_target;
      else if (!(stall || hlt_freeze)) pc <= pc + IAW'(1);

      if (br_taken || (!stall && hlt_freeze)) begin
        ifid_valid <= 1'b0;
      end else if (!stall) begin
        ifid_valid <= 1'b1;
        ifid_ir    <= imem_rdata;
        ifid_pc    <= pc;
      end

      idex_valid <= ifid_valid && !br_taken && !stall;
      idex_op    <= id_op;   idex_rs  <= id_rs;  idex_rt <= id_rt;
      idex_dest  <= id_dest; idex_wr  <= id_wr;
      idex_a     <= id_a;    idex_b   <= id_b;   idex_imm <= id_imm;
      idex_pc    <= ifid_pc;

      exmem_valid <= idex_valid;
      exmem_op    <= idex_op;   exmem_dest <= idex_dest; exmem_wr <= idex_wr;
      exmem_alu   <= alu;       exmem_b    <= fb;

      memwb_valid <= exmem_valid;
      memwb_wr    <= exmem_wr;
      memwb_hlt   <= exmem_op == OP_HLT;
      memwb_dest  <= exmem_dest;
      memwb_res   <= exmem_val;

      if (memwb_valid && memwb_hlt) halted <= 1'b1;
    end
  end

  // Register file write port (WB stage).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!halted && wb_we) begin
      regs[memwb_dest] <= memwb_res;
    end
  end
endmodule

// File: doc/pipe_mips_param.md
PIPE_MIPS_PARAM -- requirements
Module: pipe_mips_param

Interface
REQ-001: Parameter XLEN, default 32: datapath and register width, minimum 16.
REQ-002: Parameter IAW, default 10: instruction address width in words.
REQ-003: Parameter DAW, default 10: data address width in words.
REQ-004: clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005: rst_n  in  1  reset, asynchronous and active-low.
REQ-006: imem_addr  out  IAW  fetch address, driven as PC[IAW-1:0].
REQ-007: imem_rdata  in  32  instruction word, combinational read of imem_addr.
REQ-008: dmem_addr  out  DAW  data address from the EX/MEM stage.
REQ-009: dmem_wdata  out  XLEN  store data from the EX/MEM stage.
REQ-010: dmem_we  out  1  write strobe, high for one cycle per valid SW.
REQ-011: dmem_rdata  in  XLEN  load data, combinational read of dmem_addr.
REQ-012: dbg_raddr  in  5  debug register select.
REQ-013: dbg_rdata  out  XLEN  combinational contents of Reg[dbg_raddr].
REQ-014: halted  out  1  high once HLT has retired.

Function
REQ-015: Stages SHALL be IF, ID, EX, MEM, WB, single clock; each pipe register SHALL carry a valid bit, and invalid entries SHALL be bubbles with no side effects.
REQ-016: Opcodes [31:26] SHALL be: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101, LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100, BNEQZ 001101, BEQZ 001110, HLT 111111; any other opcode SHALL be executed as HLT.
REQ-017: Fields SHALL be rs [25:21], rt [20:16], rd [15:11], imm [15:0] sign-extended to XLEN; RR ops write rd; RM ops and LW write rt.
REQ-018: Arithmetic is modulo 2^XLEN; MUL keeps the low XLEN bits; SLT/SLTI compare signed and yield 1 or 0.
REQ-019: LW/SW address = rs + imm, truncated to DAW bits; SW stores rt.
REQ-020: Reg[0] SHALL read as 0; writes to it are discarded.
REQ-021: The register file SHALL be write-first: a WB write is visible to the ID read in the same cycle.
REQ-022: EX operands SHALL be forwarded, EX/MEM result having priority over MEM/WB, only from valid, register-writing producers with a nonzero destination.
REQ-023: Load-use: if EX holds a valid LW whose rt matches the ID rs or rt (nonzero), PC and IF/ID SHALL hold for 1 cycle and a bubble SHALL enter ID/EX.
REQ-024: Branches resolve in EX: BEQZ is taken when forwarded rs == 0, BNEQZ when rs != 0; target = branch address + 1 + imm.
REQ-025: A taken branch SHALL load PC with the target and invalidate IF/ID and ID/EX (2-cycle penalty); a not-taken branch costs 0 cycles.
REQ-026: Priority SHALL be: branch flush over load-use stall over normal advance.
REQ-027: A valid HLT in ID SHALL freeze PC and stop fetch (IF/ID fed bubbles); older instructions SHALL drain and retire.
REQ-028: halted SHALL rise on the edge where HLT leaves WB; from then on all state is frozen and dmem_we = 0.
REQ-029: A HLT squashed by a taken branch SHALL have no effect.
REQ-030: PC SHALL wrap modulo 2^IAW.

Reset
REQ-031: rst_n low SHALL immediately force the following: PC = 0; all valid bits = 0; all registers = 0; halted = 0; dmem_we = 0.
REQ-032: Reset asserted mid-operation SHALL abort in-flight instructions with no further register or memory writes.
REQ-033: After rst_n is released, the first posedge SHALL fetch address 0.

Verification
REQ-034: Reset: assert rst_n low between edges -> PC, halted, and dmem_we are 0 without waiting for a clock edge; dbg_rdata is 0 for all 32 registers.
REQ-035: Forwarding: program ADDI r1,r0,10; ADDI r2,r0,20; ADD r3,r1,r2; HLT -> r3 = 30, and halted rises at the 8th posedge after reset release (no stalls).
REQ-036: Load-use: ADDI r1,r0,7; SW r1,5(r0); LW r4,5(r0); ADD r5,r4,r4; HLT -> dmem write of 7 at address 5, r5 = 14, exactly one bubble inserted (halted rises at posedge 10).
REQ-037: Branch: BEQZ r0,+2; ADDI r6,r0,1; ADDI r7,r0,1; ADDI r8,r0,3; HLT -> r6 = r7 = 0, r8 = 3; with BNEQZ r0 instead, r6 = r7 = r8 set.
REQ-038: Halt: HLT followed by ADDI r9,r0,9 -> r9 stays 0, PC stays frozen, and halted holds high for 100 further cycles.
REQ-039: Mid-run reset: assert rst_n during the REQ-035 program, then release -> state matches REQ-034, and rerunning the program reproduces REQ-035 timing.
